softmax_stream_ctrl: RTL and testbench

SOFTMAX_STREAM_CTRL -- requirements
Module: softmax_stream_ctrl

---
 rtl/softmax_stream_ctrl.sv | 153 +++++++++++++++
 tb/tb_softmax_stream_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/softmax_stream_ctrl.sv
// Streaming controller that routes B2R tiles round-robin into a bank of softmax rows,
// then waits for every row and the converter to finish before flushing to the next slice.
module softmax_stream_ctrl #(
    parameter int WIDTH      = 16,
    parameter int COL        = 64,
    parameter int TILE_SIZE  = 8,
    parameter int NUM_CORES  = 2,
    parameter int BLOCK_SIZE = 2,
    parameter int NUM_SLICES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  b2r_valid,
    output logic                  b2r_ready,
    input  logic                  b2r_slice_done,
    output logic                  b2r_rst,
    output logic                  softmax_en,
    output logic [NUM_CORES*BLOCK_SIZE-1:0] softmax_valid,
    input  logic [NUM_CORES*BLOCK_SIZE-1:0] softmax_ready,
    input  logic [NUM_CORES*BLOCK_SIZE-1:0] softmax_done,
    output logic [((COL/TILE_SIZE) > 1 ? $clog2(COL/TILE_SIZE) : 1)-1:0] tile_idx,
    output logic [((NUM_CORES*BLOCK_SIZE) > 1 ? $clog2(NUM_CORES*BLOCK_SIZE) : 1)-1:0] row_idx,
    output logic [(NUM_SLICES > 1 ? $clog2(NUM_SLICES) : 1)-1:0] slice_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int ROWS      = NUM_CORES * BLOCK_SIZE;
    localparam int NUM_TILES = COL / TILE_SIZE;
    localparam int TW        = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW        = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    // Element width only matters to the datapath; here it is just sanity-checked.
    if (WIDTH < 1 || TILE_SIZE < 1 || (COL % TILE_SIZE) != 0 || ROWS < 1 || NUM_SLICES < 1)
    begin : g_bad_params
        $error("softmax_stream_ctrl: inconsistent parameters");
    end

    typedef enum logic [2:0] {IDLE, STREAM, WAIT, FLUSH, DONE} state_t;

    state_t          state, state_next;
    logic [TW-1:0]   tile_next;
    logic [RW-1:0]   row_next;
    logic [SW-1:0]   slice_next;
    logic [ROWS-1:0] row_done, row_done_next;
    logic            slice_seen, slice_seen_next;
    logic            transfer;
    logic            last_row, last_tile, last_slice;

    assign b2r_ready  = (state == STREAM) && softmax_ready[row_idx];
    assign transfer   = b2r_valid && b2r_ready;
    assign last_row   = (row_idx == RW'(ROWS - 1));
    assign last_tile  = (tile_idx == TW'(NUM_TILES - 1));
    assign last_slice = (slice_idx == SW'(NUM_SLICES - 1));

    assign b2r_rst    = (state == FLUSH);
    assign done       = (state == DONE);
    assign busy       = (state != IDLE);
    assign softmax_en = (state == STREAM) || (state == WAIT) || (state == FLUSH);

    always_comb begin
        softmax_valid = '0;
        for (int r = 0; r < ROWS; r++) begin
            softmax_valid[r] = (state == STREAM) && b2r_valid && (row_idx == RW'(r));
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_next      = state;
        tile_next       = tile_idx;
        row_next        = row_idx;
        slice_next      = slice_idx;
        row_done_next   = row_done;
        slice_seen_next = slice_seen;

        // Completion flags collect during both streaming and waiting; repeats are harmless ORs.
        if (state == STREAM || state == WAIT) begin
            row_done_next   = row_done | softmax_done;
            slice_seen_next = slice_seen | b2r_slice_done;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_next      = STREAM;
                    tile_next       = '0;
                    row_next        = '0;
                    slice_next      = '0;
                    row_done_next   = '0;
                    slice_seen_next = 1'b0;
                end
            end
            STREAM: begin
                if (transfer) begin
                    if (last_row) begin
                        row_next = '0;
                        if (last_tile) begin
                            tile_next  = '0;
                            state_next = WAIT;
                        end else begin
                            tile_next = tile_idx + 1'b1;
                        end
                    end else begin
                        row_next = row_idx + 1'b1;
                    end
                end
            end
            WAIT: begin
                if ((&row_done_next) && slice_seen_next) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                row_done_next   = '0;
                slice_seen_next = 1'b0;
                if (last_slice) begin
                    state_next = DONE;
                end else begin
                    slice_next = slice_idx + 1'b1;
                    state_next = STREAM;
                end
            end
            DONE: begin
                slice_next = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tile_idx   <= '0;
            row_idx    <= '0;
            slice_idx  <= '0;
            row_done   <= '0;
            slice_seen <= 1'b0;
        end else begin
            state      <= state_next;
            tile_idx   <= tile_next;
            row_idx    <= row_next;
            slice_idx  <= slice_next;
            row_done   <= row_done_next;
            slice_seen <= slice_seen_next;
        end
    end

endmodule

// File: tb/tb_softmax_stream_ctrl.sv
// Directed bench: default-parameter instance for streaming/flush/reset scenarios,
// plus a 3-row, 6-tile instance for non-power-of-two wrap behaviour.
module tb_softmax_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, b2r_valid, b2r_slice_done;
    logic [3:0] softmax_ready, softmax_done;
    logic       b2r_ready, b2r_rst, softmax_en, busy, done;
    logic [3:0] softmax_valid;
    logic [2:0] tile_idx;
    logic [1:0] row_idx, slice_idx;

    logic       s_start, s_b2r_valid, s_b2r_slice_done;
    logic [2:0] s_softmax_ready, s_softmax_done;
    logic       s_b2r_ready, s_b2r_rst, s_softmax_en, s_busy, s_done;
    logic [2:0] s_softmax_valid;
    logic [2:0] s_tile_idx;
    logic [1:0] s_row_idx, s_slice_idx;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    softmax_stream_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .b2r_valid(b2r_valid), .b2r_ready(b2r_ready), .b2r_slice_done(b2r_slice_done),
        .b2r_rst(b2r_rst), .softmax_en(softmax_en), .softmax_valid(softmax_valid),
        .softmax_ready(softmax_ready), .softmax_done(softmax_done),
        .tile_idx(tile_idx), .row_idx(row_idx), .slice_idx(slice_idx),
        .busy(busy), .done(done)
    );

    softmax_stream_ctrl #(.COL(48), .NUM_CORES(3), .BLOCK_SIZE(1)) dut_sweep (
        .clk(clk), .rst(rst), .start(s_start),
        .b2r_valid(s_b2r_valid), .b2r_ready(s_b2r_ready), .b2r_slice_done(s_b2r_slice_done),
        .b2r_rst(s_b2r_rst), .softmax_en(s_softmax_en), .softmax_valid(s_softmax_valid),
        .softmax_ready(s_softmax_ready), .softmax_done(s_softmax_done),
        .tile_idx(s_tile_idx), .row_idx(s_row_idx), .slice_idx(s_slice_idx),
        .busy(s_busy), .done(s_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dut_vec();
        return {16'h0, b2r_ready, b2r_rst, softmax_en, busy, done,
                softmax_valid, tile_idx, row_idx, slice_idx};
    endfunction

    function automatic logic [31:0] exp_vec(input logic rdy, input logic rs, input logic en,
                                            input logic bs, input logic dn, input logic [3:0] v,
                                            input logic [2:0] t, input logic [1:0] r,
                                            input logic [1:0] s);
        return {16'h0, rdy, rs, en, bs, dn, v, t, r, s};
    endfunction

    task automatic start_head();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives one slice of 32 tiles; bp_k stalls row 2 for 5 cycles, early_k pulses
    // b2r_slice_done, abort_k asserts rst on that transfer instead of completing it.
    task automatic run_stream(input int slice, input int bp_k, input int early_k, input int abort_k);
        for (int k = 0; k < 32; k++) begin
            b2r_valid     = 1'b1;
            softmax_ready = 4'hf;
            if (k == abort_k) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                #1 check("reset_abort", dut_vec(), 32'h0);
                return;
            end
            if (k == bp_k) begin
                softmax_ready[2] = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    #1 check("backpressure", dut_vec(),
                             exp_vec(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 3'(k / 4), 2'd2, 2'(slice)));
                    tick();
                end
                softmax_ready = 4'hf;
            end
            b2r_slice_done = (k == early_k);
            start          = (k == 5);
            #1 check("stream", dut_vec(),
                     exp_vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'(1 << (k % 4)), 3'(k / 4), 2'(k % 4), 2'(slice)));
            tick();
            b2r_slice_done = 1'b0;
            start          = 1'b0;
        end
        #1 check("wait_entry", dut_vec(),
                 exp_vec(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 3'd0, 2'd0, 2'(slice)));
    endtask

    // mode 0: row pulses then slice_done; 1: row pulses only; 2: rows 0-2, duplicate, then row 3 + slice_done together.
    task automatic run_wait(input int slice, input int mode);
        logic [31:0] wait_v;
        wait_v = exp_vec(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 3'd0, 2'd0, 2'(slice));
        for (int r = 0; r < 4; r++) begin
            if (mode == 2 && r == 3) begin
                softmax_done = 4'b0001;
            end else begin
                softmax_done = 4'(1 << r);
            end
            #1 check("wait_hold", dut_vec(), wait_v);
            tick();
            softmax_done = 4'b0000;
        end
        if (mode != 1) begin
            b2r_slice_done = 1'b1;
            if (mode == 2) softmax_done = 4'b1000;
            #1 check("wait_last", dut_vec(), wait_v);
            tick();
            b2r_slice_done = 1'b0;
            softmax_done   = 4'b0000;
        end
        #1 check("flush", dut_vec(),
                 exp_vec(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 3'd0, 2'd0, 2'(slice)));
        tick();
        if (slice == 3) begin
            #1 check("done_pulse", dut_vec() & 32'hfffc,
                     exp_vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'd0, 2'd0, 2'd0));
            tick();
            #1 check("idle_after_done", dut_vec(), 32'h0);
            tick();
            #1 check("idle_hold", dut_vec(), 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; b2r_valid = 1'b1; b2r_slice_done = 1'b0;
        softmax_ready = 4'hf; softmax_done = 4'h0;
        s_start = 1'b0; s_b2r_valid = 1'b0; s_b2r_slice_done = 1'b0;
        s_softmax_ready = 3'h0; s_softmax_done = 3'h0;
        tick();
        tick();
        check("reset_state", dut_vec(), 32'h0);
        rst = 1'b0;
        tick();
        check("idle", dut_vec(), 32'h0);

        // Head 1: nominal, early slice_done + backpressure, simultaneous flags, final done.
        start_head();
        run_stream(0, -1, -1, -1); run_wait(0, 0);
        run_stream(1, 10, 3, -1);  run_wait(1, 1);
        run_stream(2, -1, -1, -1); run_wait(2, 2);
        run_stream(3, 2, -1, -1);  run_wait(3, 0);

        // Head 2: reset on transfer 17 of slice 2, then a fresh head starts at slice 0.
        start_head();
        run_stream(0, -1, -1, -1); run_wait(0, 0);
        run_stream(1, -1, -1, -1); run_wait(1, 0);
        run_stream(2, -1, -1, 16);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_done_after_abort", dut_vec(), 32'h0);
        end
        start_head();
        run_stream(0, -1, -1, -1); run_wait(0, 0);

        // Sweep instance: 3 rows x 6 tiles = 18 transfers per slice.
        b2r_valid = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int k = 0; k < 18; k++) begin
            s_b2r_valid     = 1'b1;
            s_softmax_ready = 3'h7;
            #1 check("sweep_stream",
                     {24'h0, s_b2r_ready, s_softmax_valid, s_tile_idx, s_row_idx},
                     {24'h0, 1'b1, 3'(1 << (k % 3)), 3'(k / 3), 2'(k % 3)});
            tick();
        end
        #1 check("sweep_wait",
                 {24'h0, s_b2r_ready, s_softmax_en, s_softmax_valid, s_tile_idx, s_row_idx},
                 {24'h0, 1'b0, 1'b1, 3'b000, 3'd0, 2'd0});
        s_softmax_done   = 3'h7;
        s_b2r_slice_done = 1'b1;
        tick();
        s_softmax_done   = 3'h0;
        s_b2r_slice_done = 1'b0;
        #1 check("sweep_flush", {31'h0, s_b2r_rst}, 32'h1);
        tick();
        #1 check("sweep_next_slice",
                 {24'h0, s_b2r_ready, s_softmax_valid, s_tile_idx, s_slice_idx},
                 {24'h0, 1'b1, 3'b001, 3'd0, 2'd1});

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
